mul4_issue_ctrl: RTL and testbench

MUL4_ISSUE_CTRL -- requirements
Module: mul4_issue_ctrl

---
 rtl/mul4_issue_ctrl_pkg.sv | 30 +++
 rtl/mul4_opq.sv | 81 ++++++++
 rtl/mul4_issue_ctrl.sv | 172 +++++++++++++++++
 tb/tb_mul4_issue_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul4_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul4_issue_ctrl_pkg
// Description : Shared types and defaults for the 4x4 multiplier issue
//               controller: FSM state encoding, operand-pair record and
//               default queue depth / timeout budget.
// Revision    : 1.0 - initial release
// ============================================================================
package mul4_issue_ctrl_pkg;

    localparam int c_default_depth   = 4;
    localparam int c_default_timeout = 15;
    // Timeout counter width; wide enough for the largest legal TIMEOUT (255).
    localparam int c_tmo_w           = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_START   = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_OUT     = 3'd4
    } state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
    } opnd_pair_t;

endpackage : mul4_issue_ctrl_pkg
`default_nettype wire

// File: rtl/mul4_opq.sv
`default_nettype none
// ============================================================================
// Module      : mul4_opq
// Description : Flop-based FIFO of operand pairs feeding the issue FSM.
//               A push is taken only when not full, so a push/pop pair
//               offered while full never overwrites the head entry.
// Ports       : blif_clk_net / blif_reset_net  clock, async active-low reset
//               push_valid/push_ready/push_data  write side (ready = not full)
//               pop / pop_data / empty          read side (pop only if !empty)
// Revision    : 1.0 - initial release
// ============================================================================
module mul4_opq
    import mul4_issue_ctrl_pkg::*;
#(
    parameter int DEPTH = c_default_depth
) (
    input  logic       blif_clk_net,
    input  logic       blif_reset_net,
    input  logic       push_valid,
    output logic       push_ready,
    input  opnd_pair_t push_data,
    input  logic       pop,
    output opnd_pair_t pop_data,
    output logic       empty
);

    localparam int                 c_ptr_w    = $clog2(DEPTH);
    localparam int                 c_cnt_w    = $clog2(DEPTH) + 1;
    localparam logic [c_cnt_w-1:0] c_full_cnt = c_cnt_w'(DEPTH);

    opnd_pair_t         r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_full;
    logic w_push;
    logic w_pop;

    assign w_full     = (r_count == c_full_cnt);
    assign empty      = (r_count == '0);
    assign push_ready = ~w_full;
    assign w_push     = push_valid & ~w_full;
    assign w_pop      = pop & ~empty;
    assign pop_data   = r_mem[r_rd_ptr];

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_entry
            always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
                if (!blif_reset_net) begin
                    r_mem[i] <= '0;
                end else if (w_push && (r_wr_ptr == c_ptr_w'(i))) begin
                    r_mem[i] <= push_data;
                end
            end
        end
    endgenerate

    // Pointers are exactly log2(DEPTH) wide, so wrap is the natural overflow.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : mul4_opq
`default_nettype wire

// File: rtl/mul4_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mul4_issue_ctrl
// Description : Queues 4-bit operand pairs and issues them one at a time to
//               an external 4x4 shift-add multiplier, handling its START /
//               READY handshake, a per-operation timeout and result
//               back-pressure.
// Ports       : blif_clk_net, blif_reset_net   clock, async active-low reset
//               in_valid/in_ready/in_a/in_b     operand input stream
//               mul_start/mul_a/mul_b           command to the multiplier
//               mul_ready/mul_p                 status/product from multiplier
//               res_valid/res_ready/res_p       product output stream
//               err_timeout                     sticky abort flag
//               busy                            FSM active or queue non-empty
// Revision    : 1.0 - initial release
// ============================================================================
module mul4_issue_ctrl
    import mul4_issue_ctrl_pkg::*;
#(
    parameter int DEPTH   = c_default_depth,
    parameter int TIMEOUT = c_default_timeout
) (
    input  logic       blif_clk_net,
    input  logic       blif_reset_net,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_a,
    input  logic [3:0] in_b,
    output logic       mul_start,
    output logic [3:0] mul_a,
    output logic [3:0] mul_b,
    input  logic       mul_ready,
    input  logic [7:0] mul_p,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_p,
    output logic       err_timeout,
    output logic       busy
);

    // The wait budget is spent on the cycle whose count equals TIMEOUT-1;
    // the counter then lands on TIMEOUT as the abort is registered.
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(TIMEOUT - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_tmo_w-1:0] r_tmo_cnt;
    logic [3:0]         r_mul_a;
    logic [3:0]         r_mul_b;
    logic [7:0]         r_res_p;
    logic               r_err_timeout;

    logic       w_q_empty;
    opnd_pair_t w_q_head;
    opnd_pair_t w_q_in;
    logic       w_pop;
    logic       w_capture;
    logic       w_abort;
    logic       w_tmo_clr;
    logic       w_tmo_inc;

    assign w_q_in = '{a: in_a, b: in_b};

    mul4_opq #(
        .DEPTH (DEPTH)
    ) u_opq (
        .blif_clk_net   (blif_clk_net),
        .blif_reset_net (blif_reset_net),
        .push_valid     (in_valid),
        .push_ready     (in_ready),
        .push_data      (w_q_in),
        .pop            (w_pop),
        .pop_data       (w_q_head),
        .empty          (w_q_empty)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        w_tmo_clr   = 1'b0;
        w_tmo_inc   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_q_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_tmo_clr   = 1'b1;
                w_state_nxt = ST_WAIT_LO;
            end
            ST_WAIT_LO: begin
                // READY still high here belongs to the previous product.
                w_tmo_inc = 1'b1;
                if (r_tmo_cnt == c_tmo_last) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (!mul_ready) begin
                    w_state_nxt = ST_WAIT_HI;
                end
            end
            ST_WAIT_HI: begin
                // A product arriving on the last budgeted cycle is still kept.
                w_tmo_inc = 1'b1;
                if (mul_ready) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_OUT;
                end else if (r_tmo_cnt == c_tmo_last) begin
                    w_abort     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (res_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            r_mul_a       <= '0;
            r_mul_b       <= '0;
            r_res_p       <= '0;
            r_err_timeout <= 1'b0;
            r_tmo_cnt     <= '0;
        end else begin
            // Operands only change on a pop, so they stay put for the whole
            // START..WAIT_HI window of the operation they belong to.
            if (w_pop) begin
                r_mul_a <= w_q_head.a;
                r_mul_b <= w_q_head.b;
            end
            if (w_capture) begin
                r_res_p <= mul_p;
            end
            if (w_abort) begin
                r_err_timeout <= 1'b1;
            end
            if (w_tmo_clr) begin
                r_tmo_cnt <= '0;
            end else if (w_tmo_inc) begin
                r_tmo_cnt <= r_tmo_cnt + c_tmo_w'(1);
            end
        end
    end

    assign mul_start   = (r_state == ST_START);
    assign mul_a       = r_mul_a;
    assign mul_b       = r_mul_b;
    assign res_valid   = (r_state == ST_OUT);
    assign res_p       = r_res_p;
    assign err_timeout = r_err_timeout;
    assign busy        = (r_state != ST_IDLE) || !w_q_empty;

endmodule : mul4_issue_ctrl
`default_nettype wire

// File: tb/tb_mul4_issue_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mul4_issue_ctrl
// Description : Self-checking bench for mul4_issue_ctrl. A behavioural
//               multiplier keeps READY high for two cycles after START
//               (stale), drops it for two cycles, then raises it with the
//               new product. Directed vectors plus hand-written sequences
//               for queue-full, back-pressure, timeout and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul4_issue_ctrl;

    localparam int c_depth   = 4;
    localparam int c_timeout = 15;

    logic       blif_clk_net   = 1'b0;
    logic       blif_reset_net = 1'b0;
    logic       in_valid       = 1'b0;
    logic       in_ready;
    logic [3:0] in_a           = '0;
    logic [3:0] in_b           = '0;
    logic       mul_start;
    logic [3:0] mul_a;
    logic [3:0] mul_b;
    logic       mul_ready;
    logic [7:0] mul_p;
    logic       res_valid;
    logic       res_ready      = 1'b1;
    logic [7:0] res_p;
    logic       err_timeout;
    logic       busy;

    always #5 blif_clk_net = ~blif_clk_net;

    mul4_issue_ctrl #(
        .DEPTH   (c_depth),
        .TIMEOUT (c_timeout)
    ) u_dut (
        .blif_clk_net   (blif_clk_net),
        .blif_reset_net (blif_reset_net),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .in_b           (in_b),
        .mul_start      (mul_start),
        .mul_a          (mul_a),
        .mul_b          (mul_b),
        .mul_ready      (mul_ready),
        .mul_p          (mul_p),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_p          (res_p),
        .err_timeout    (err_timeout),
        .busy           (busy)
    );

    // ---------------- multiplier model ----------------
    logic       mdl_stuck = 1'b0;
    logic [2:0] mdl_cnt;

    always @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            mul_ready <= 1'b1;
            mul_p     <= 8'hAA;
            mdl_cnt   <= 3'd0;
        end else if (mdl_stuck) begin
            mul_ready <= 1'b0;
            mdl_cnt   <= 3'd0;
        end else if (mul_start) begin
            mdl_cnt <= 3'd1;
        end else if (mdl_cnt != 3'd0) begin
            if (mdl_cnt == 3'd2) mul_ready <= 1'b0;
            if (mdl_cnt == 3'd4) begin
                mul_ready <= 1'b1;
                mul_p     <= 8'(mul_a) * 8'(mul_b);
                mdl_cnt   <= 3'd0;
            end else begin
                mdl_cnt <= mdl_cnt + 3'd1;
            end
        end
    end

    int start_cnt = 0;
    always @(posedge blif_clk_net) if (mul_start) start_cnt++;

    // ---------------- checking helpers ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] b, output logic acc);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        acc      = in_ready;
        @(negedge blif_clk_net);
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input string name, input logic [7:0] exp);
        int n = 0;
        while (!res_valid && n < 40) begin
            @(negedge blif_clk_net);
            n++;
        end
        if (!res_valid) begin
            checks++;
            failures++;
            $display("FAIL %s: no res_valid within 40 cycles, expected 0x%0h", name, exp);
        end else begin
            check(name, {24'd0, res_p}, {24'd0, exp});
            if (res_ready) @(negedge blif_clk_net);
        end
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!mul_start && n < 20) begin
            @(negedge blif_clk_net);
            n++;
        end
        check(name, {31'd0, mul_start}, 32'd1);
    endtask

    // {in_ready, mul_start, mul_a, mul_b, res_valid, res_p, err_timeout, busy}
    function automatic logic [20:0] out_vec();
        return {in_ready, mul_start, mul_a, mul_b, res_valid, res_p, err_timeout, busy};
    endfunction

    localparam logic [20:0] c_reset_vec = {1'b1, 20'd0};

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic       acc;
        logic [7:0] held;
        logic       stable;
        int         s0;
        int         n;

        vecs[0] = '{a: 4'd3,  b: 4'd5,  p: 8'h0F};
        vecs[1] = '{a: 4'd15, b: 4'd15, p: 8'hE1};
        vecs[2] = '{a: 4'd0,  b: 4'd9,  p: 8'h00};
        vecs[3] = '{a: 4'd1,  b: 4'd1,  p: 8'h01};
        vecs[4] = '{a: 4'd15, b: 4'd1,  p: 8'h0F};
        vecs[5] = '{a: 4'd7,  b: 4'd9,  p: 8'h3F};
        vecs[6] = '{a: 4'd12, b: 4'd10, p: 8'h78};
        vecs[7] = '{a: 4'd8,  b: 4'd8,  p: 8'h40};

        // ---- reset state ----
        repeat (2) @(negedge blif_clk_net);
        check("reset_outputs", {11'd0, out_vec()}, {11'd0, c_reset_vec});
        blif_reset_net = 1'b1;
        @(negedge blif_clk_net);

        // ---- single operation 3*5 ----
        s0 = start_cnt;
        push(4'd3, 4'd5, acc);
        check("single_push_acc", {31'd0, acc}, 32'd1);
        wait_result("single_res_p", 8'h0F);
        check("single_start_pulses", start_cnt - s0, 32'd1);
        check("single_busy_idle", {31'd0, busy}, 32'd0);

        // ---- table-driven vectors ----
        for (int i = 0; i < 8; i++) begin
            s0 = start_cnt;
            push(vecs[i].a, vecs[i].b, acc);
            wait_result($sformatf("vec%0d_res_p", i), vecs[i].p);
            check($sformatf("vec%0d_starts", i), start_cnt - s0, 32'd1);
        end

        // ---- stale READY, latency START->res_valid is 6 ----
        push(4'd15, 4'd15, acc);
        wait_start("stale_start_seen");
        n = 0;
        stable = 1'b1;
        do begin
            @(negedge blif_clk_net);
            n++;
            if (mul_a !== 4'd15 || mul_b !== 4'd15) stable = 1'b0;
        end while (!res_valid && n < 20);
        check("stale_latency", n, 32'd6);
        check("stale_operands_stable", {31'd0, stable}, 32'd1);
        wait_result("stale_res_p", 8'hE1);

        // ---- queue full while stalled in OUT ----
        res_ready = 1'b0;
        s0 = start_cnt;
        push(4'd1, 4'd2, acc);
        wait_result("full_p0", 8'h02);
        push(4'd3, 4'd4, acc);   check("full_push1", {31'd0, acc}, 32'd1);
        push(4'd5, 4'd6, acc);   check("full_push2", {31'd0, acc}, 32'd1);
        push(4'd7, 4'd8, acc);   check("full_push3", {31'd0, acc}, 32'd1);
        push(4'd9, 4'd10, acc);  check("full_push4", {31'd0, acc}, 32'd1);
        push(4'd11, 4'd12, acc); check("full_push5_refused", {31'd0, acc}, 32'd0);

        // ---- back-pressure: 10 cycles of res_ready=0 ----
        held   = res_p;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge blif_clk_net);
            if (res_p !== held || !res_valid) stable = 1'b0;
        end
        check("bp_res_stable", {31'd0, stable}, 32'd1);
        check("bp_no_new_start", start_cnt - s0, 32'd1);
        res_ready = 1'b1;
        n = 0;
        do begin
            @(negedge blif_clk_net);
            n++;
        end while (!mul_start && n < 5);
        check("bp_restart_latency", n, 32'd2);
        wait_result("full_p1", 8'h0C);
        wait_result("full_p2", 8'h1E);
        wait_result("full_p3", 8'h38);
        wait_result("full_p4", 8'h5A);
        check("full_drained_busy", {31'd0, busy}, 32'd0);
        check("full_total_starts", start_cnt - s0, 32'd5);

        // ---- pointer wrap over 8 further pushes ----
        for (int i = 0; i < 8; i++) begin
            logic [3:0] a;
            logic [3:0] b;
            a = 4'(2 * i + 1);
            b = 4'(15 - i);
            push(a, b, acc);
            wait_result($sformatf("wrap%0d_res_p", i), 8'(a) * 8'(b));
        end

        // ---- timeout with READY stuck low ----
        mdl_stuck = 1'b1;
        push(4'd2, 4'd3, acc);
        push(4'd5, 4'd6, acc);
        wait_start("tmo_start_seen");
        n = 0;
        stable = 1'b0;
        while (!err_timeout && n < 40) begin
            @(negedge blif_clk_net);
            n++;
            if (res_valid) stable = 1'b1;
        end
        check("tmo_cycles_to_err", n, 32'd16);
        check("tmo_no_res_valid", {31'd0, stable}, 32'd0);
        mdl_stuck = 1'b0;
        wait_result("tmo_next_res_p", 8'h1E);
        check("tmo_err_sticky", {31'd0, err_timeout}, 32'd1);
        check("tmo_busy_idle", {31'd0, busy}, 32'd0);

        // ---- async reset in WAIT_HI with 2 entries queued ----
        push(4'd9, 4'd9, acc);
        push(4'd2, 4'd2, acc);
        push(4'd3, 4'd3, acc);
        repeat (3) @(negedge blif_clk_net);
        #2 blif_reset_net = 1'b0;
        #1 check("midreset_outputs", {11'd0, out_vec()}, {11'd0, c_reset_vec});
        repeat (2) @(negedge blif_clk_net);
        blif_reset_net = 1'b1;
        s0 = start_cnt;
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge blif_clk_net);
            if (busy || res_valid) stable = 1'b0;
        end
        check("postreset_queue_empty", {31'd0, stable}, 32'd1);
        check("postreset_no_start", start_cnt - s0, 32'd0);
        push(4'd6, 4'd11, acc);
        wait_result("postreset_res_p", 8'h42);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_mul4_issue_ctrl
`default_nettype wire
